// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage_if
//  Brief    : Fetch-stage bus: instruction-memory port, EX redirect, decode hand-off.
//  Revision : 1.0
// ============================================================================
interface fetch_stage_if #(
   parameter int XLEN = 32
);
   logic            ImemReq;
   logic [XLEN-1:0] ImemAddr;
   logic [31:0]     ImemRData;
   logic            PCSrcE;
   logic [XLEN-1:0] PCTargetE;
   logic            StallD;
   logic            ValidD;
   logic [31:0]     InstrD;
   logic [XLEN-1:0] PCD;
   logic [XLEN-1:0] PCPlus4D;

   modport master (
      output ImemReq, ImemAddr, ValidD, InstrD, PCD, PCPlus4D,
      input  ImemRData, PCSrcE, PCTargetE, StallD
   );

   modport slave (
      input  ImemReq, ImemAddr, ValidD, InstrD, PCD, PCPlus4D,
      output ImemRData, PCSrcE, PCTargetE, StallD
   );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage
//  Brief    : RV32I instruction fetch: PC, 1-cycle imem requests, in-order queue to decode.
//  Revision : 1.0
// ============================================================================
module fetch_stage #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              QDEPTH   = 2
) (
   input  wire logic         clk,
   input  wire logic         reset,
   fetch_stage_if.master     bus
);
   localparam int          c_PW  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int          c_CW  = $clog2(QDEPTH + 1);
   localparam logic [31:0] c_NOP = 32'h0000_0013;

   logic [31:0]     r_q_instr [QDEPTH];
   logic [XLEN-1:0] r_q_pc    [QDEPTH];
   logic [c_PW-1:0] r_head;
   logic [c_PW-1:0] r_tail;
   logic [c_CW-1:0] r_count;
   logic            r_inflight;
   logic [XLEN-1:0] r_inflight_pc;
   logic [XLEN-1:0] r_pcf;

   logic            w_valid;
   logic            w_deq;
   logic            w_enq;
   logic            w_req;
   logic [c_CW:0]   w_occ;
   logic [c_CW-1:0] w_count_nxt;

   function automatic logic [c_PW-1:0] f_inc(input logic [c_PW-1:0] p);
      return (p == c_PW'(QDEPTH - 1)) ? '0 : p + c_PW'(1);
   endfunction

   // A response returning during a redirect belongs to the wrong path and is never enqueued.
   always_comb begin
      w_valid     = (r_count != '0);
      w_deq       = w_valid & ~bus.StallD;
      w_enq       = r_inflight & ~bus.PCSrcE;
      w_occ       = {1'b0, r_count} + (c_CW + 1)'(r_inflight) - (c_CW + 1)'(w_deq);
      w_req       = reset & ~bus.PCSrcE & (w_occ < (c_CW + 1)'(QDEPTH));
      w_count_nxt = r_count + c_CW'(w_enq) - c_CW'(w_deq);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pcf         <= RESET_PC;
         r_head        <= '0;
         r_tail        <= '0;
         r_count       <= '0;
         r_inflight    <= 1'b0;
         r_inflight_pc <= '0;
      end else if (bus.PCSrcE) begin
         r_pcf      <= bus.PCTargetE & ~XLEN'(3);
         r_head     <= '0;
         r_tail     <= '0;
         r_count    <= '0;
         r_inflight <= 1'b0;
      end else begin
         if (w_enq) r_tail <= f_inc(r_tail);
         if (w_deq) r_head <= f_inc(r_head);
         r_count    <= w_count_nxt;
         r_inflight <= w_req;
         if (w_req) begin
            r_inflight_pc <= r_pcf;
            r_pcf         <= r_pcf + XLEN'(4);
         end
      end
   end

   // Queue payload needs no reset: it is only observed through w_valid.
   always_ff @(posedge clk) begin
      if (w_enq) begin
         r_q_instr[r_tail] <= bus.ImemRData;
         r_q_pc[r_tail]    <= r_inflight_pc;
      end
   end

   assign bus.ImemReq  = w_req;
   assign bus.ImemAddr = r_pcf;
   assign bus.ValidD   = w_valid;
   assign bus.InstrD   = w_valid ? r_q_instr[r_head] : c_NOP;
   assign bus.PCD      = w_valid ? r_q_pc[r_head] : '0;
   assign bus.PCPlus4D = w_valid ? r_q_pc[r_head] + XLEN'(4) : '0;
endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_stage
//  Brief    : Self-checking bench for fetch_stage with directed and random scenarios.
//  Revision : 1.0
// ============================================================================
module tb_fetch_stage;
   localparam logic [31:0] c_KEY = 32'hA5A5_0000;
   localparam logic [31:0] c_NOP = 32'h0000_0013;

   logic clk = 1'b0;
   logic reset_n;
   int   n_checks = 0;
   int   n_fail   = 0;

   fetch_stage_if #(.XLEN(32)) bus ();

   fetch_stage #(.XLEN(32), .RESET_PC(32'h0), .QDEPTH(2)) dut (
      .clk   (clk),
      .reset (reset_n),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   // Synchronous instruction memory, one-cycle read latency.
   always @(posedge clk) begin
      if (bus.ImemReq) bus.ImemRData <= bus.ImemAddr ^ c_KEY;
   end

   task automatic tick(input logic st, input logic rd, input logic [31:0] tg);
      @(negedge clk);
      bus.StallD    = st;
      bus.PCSrcE    = rd;
      bus.PCTargetE = tg;
      #1;
   endtask

   // Leaves the bench 1ns into cycle 0 after reset release.
   task automatic do_reset;
      reset_n       = 1'b0;
      bus.StallD    = 1'b0;
      bus.PCSrcE    = 1'b0;
      bus.PCTargetE = '0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
   endtask

   task automatic test_reset;
      @(negedge clk);
      reset_n       = 1'b0;
      bus.StallD    = 1'b0;
      bus.PCSrcE    = 1'b0;
      bus.PCTargetE = '0;
      #1;
      n_checks++; if (bus.ValidD !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%0h want=0", bus.ValidD); end
      n_checks++; if (bus.InstrD !== c_NOP) begin n_fail++; $display("FAIL reset_instr got=%0h want=%0h", bus.InstrD, c_NOP); end
      n_checks++; if (bus.PCD !== 32'h0) begin n_fail++; $display("FAIL reset_pcd got=%0h want=0", bus.PCD); end
      n_checks++; if (bus.PCPlus4D !== 32'h0) begin n_fail++; $display("FAIL reset_pcp4 got=%0h want=0", bus.PCPlus4D); end
      n_checks++; if (bus.ImemReq !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%0h want=0", bus.ImemReq); end
      n_checks++; if (bus.ImemAddr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got=%0h want=0", bus.ImemAddr); end
   endtask

   task automatic test_stream;
      logic [31:0] pc;
      do_reset();
      n_checks++; if (bus.ImemReq !== 1'b1 || bus.ImemAddr !== 32'h0) begin n_fail++; $display("FAIL stream_c0_req got=%0h/%0h want=1/0", bus.ImemReq, bus.ImemAddr); end
      tick(1'b0, 1'b0, '0);
      n_checks++; if (bus.ValidD !== 1'b0 || bus.ImemAddr !== 32'h4) begin n_fail++; $display("FAIL stream_c1 valid/addr got=%0h/%0h want=0/4", bus.ValidD, bus.ImemAddr); end
      for (int k = 2; k < 10; k++) begin
         tick(1'b0, 1'b0, '0);
         pc = 32'(4 * (k - 2));
         n_checks++; if (bus.ValidD !== 1'b1 || bus.PCD !== pc) begin n_fail++; $display("FAIL stream_pcd c%0d got=%0h/%0h want=1/%0h", k, bus.ValidD, bus.PCD, pc); end
         n_checks++; if (bus.InstrD !== (pc ^ c_KEY) || bus.PCPlus4D !== pc + 32'd4) begin n_fail++; $display("FAIL stream_instr c%0d got=%0h/%0h want=%0h/%0h", k, bus.InstrD, bus.PCPlus4D, pc ^ c_KEY, pc + 32'd4); end
      end
   endtask

   task automatic test_stall;
      logic [31:0] pc;
      do_reset();
      for (int k = 1; k < 4; k++) tick(1'b0, 1'b0, '0);
      for (int s = 0; s < 3; s++) begin
         tick(1'b1, 1'b0, '0);
         n_checks++; if (bus.PCD !== 32'h8 || bus.InstrD !== (32'h8 ^ c_KEY)) begin n_fail++; $display("FAIL stall_hold s%0d got=%0h/%0h want=8/%0h", s, bus.PCD, bus.InstrD, 32'h8 ^ c_KEY); end
         n_checks++; if (bus.ImemReq !== 1'b0) begin n_fail++; $display("FAIL stall_noreq s%0d got=%0h want=0", s, bus.ImemReq); end
      end
      for (int k = 0; k < 3; k++) begin
         tick(1'b0, 1'b0, '0);
         pc = 32'(8 + 4 * k);
         n_checks++; if (bus.ValidD !== 1'b1 || bus.PCD !== pc) begin n_fail++; $display("FAIL stall_release k%0d got=%0h/%0h want=1/%0h", k, bus.ValidD, bus.PCD, pc); end
      end
   endtask

   task automatic test_redirect;
      do_reset();
      for (int k = 1; k < 4; k++) tick(1'b0, 1'b0, '0);
      tick(1'b1, 1'b0, '0);
      tick(1'b1, 1'b0, '0);
      tick(1'b1, 1'b1, 32'h100);
      n_checks++; if (bus.ImemReq !== 1'b0) begin n_fail++; $display("FAIL redir_noreq got=%0h want=0", bus.ImemReq); end
      tick(1'b0, 1'b0, '0);
      n_checks++; if (bus.ValidD !== 1'b0 || bus.InstrD !== c_NOP) begin n_fail++; $display("FAIL redir_flush got=%0h/%0h want=0/%0h", bus.ValidD, bus.InstrD, c_NOP); end
      n_checks++; if (bus.ImemReq !== 1'b1 || bus.ImemAddr !== 32'h100) begin n_fail++; $display("FAIL redir_addr got=%0h/%0h want=1/100", bus.ImemReq, bus.ImemAddr); end
      tick(1'b0, 1'b0, '0);
      n_checks++; if (bus.ValidD !== 1'b0) begin n_fail++; $display("FAIL redir_gap got=%0h want=0", bus.ValidD); end
      tick(1'b0, 1'b0, '0);
      n_checks++; if (bus.ValidD !== 1'b1 || bus.PCD !== 32'h100 || bus.InstrD !== (32'h100 ^ c_KEY)) begin n_fail++; $display("FAIL redir_target got=%0h/%0h/%0h want=1/100/%0h", bus.ValidD, bus.PCD, bus.InstrD, 32'h100 ^ c_KEY); end
   endtask

   task automatic test_redirect_drop;
      do_reset();
      for (int k = 1; k < 6; k++) tick(1'b0, 1'b0, '0);
      tick(1'b0, 1'b1, 32'h200);
      for (int i = 0; i < 6; i++) begin
         tick(1'b0, 1'b0, '0);
         n_checks++; if (bus.ValidD === 1'b1 && bus.PCD === 32'h14) begin n_fail++; $display("FAIL drop_wrongpath i%0d got=%0h want!=14", i, bus.PCD); end
         if (i == 2) begin
            n_checks++; if (bus.ValidD !== 1'b1 || bus.PCD !== 32'h200) begin n_fail++; $display("FAIL drop_target got=%0h/%0h want=1/200", bus.ValidD, bus.PCD); end
         end
      end
   endtask

   task automatic test_misaligned;
      do_reset();
      tick(1'b0, 1'b0, '0);
      tick(1'b0, 1'b0, '0);
      tick(1'b0, 1'b1, 32'h103);
      tick(1'b0, 1'b0, '0);
      n_checks++; if (bus.ImemAddr !== 32'h100) begin n_fail++; $display("FAIL misalign_addr got=%0h want=100", bus.ImemAddr); end
      tick(1'b0, 1'b0, '0);
      tick(1'b0, 1'b0, '0);
      n_checks++; if (bus.ValidD !== 1'b1 || bus.PCD !== 32'h100) begin n_fail++; $display("FAIL misalign_pcd got=%0h/%0h want=1/100", bus.ValidD, bus.PCD); end
   endtask

   task automatic test_async_reset;
      do_reset();
      for (int k = 1; k < 5; k++) tick(1'b0, 1'b0, '0);
      @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      n_checks++; if (bus.ValidD !== 1'b0 || bus.InstrD !== c_NOP) begin n_fail++; $display("FAIL areset_out got=%0h/%0h want=0/%0h", bus.ValidD, bus.InstrD, c_NOP); end
      n_checks++; if (bus.ImemReq !== 1'b0 || bus.ImemAddr !== 32'h0) begin n_fail++; $display("FAIL areset_req got=%0h/%0h want=0/0", bus.ImemReq, bus.ImemAddr); end
      do_reset();
      n_checks++; if (bus.ImemReq !== 1'b1 || bus.ImemAddr !== 32'h0) begin n_fail++; $display("FAIL areset_restart got=%0h/%0h want=1/0", bus.ImemReq, bus.ImemAddr); end
      tick(1'b0, 1'b0, '0);
      tick(1'b0, 1'b0, '0);
      n_checks++; if (bus.ValidD !== 1'b1 || bus.PCD !== 32'h0) begin n_fail++; $display("FAIL areset_first got=%0h/%0h want=1/0", bus.ValidD, bus.PCD); end
   endtask

   // Reference: decode must see the architectural PC sequence, restarting at each
   // redirect target, and a live instruction no later than 2 cycles after a restart.
   task automatic test_random;
      logic [31:0] exp_pc;
      logic [31:0] tg;
      logic        st;
      logic        rd;
      int          since;
      do_reset();
      exp_pc = 32'h0;
      since  = 0;
      for (int c = 0; c < 400; c++) begin
         st = ($urandom_range(0, 9) < 3);
         rd = ($urandom_range(0, 19) == 0);
         tg = 32'($urandom_range(0, 1023));
         tick(st, rd, tg);
         since++;
         if (bus.ValidD === 1'b1) begin
            n_checks++; if (bus.PCD !== exp_pc || bus.InstrD !== (exp_pc ^ c_KEY) || bus.PCPlus4D !== exp_pc + 32'd4) begin
               n_fail++; $display("FAIL rand_head c%0d got=%0h/%0h/%0h want=%0h/%0h/%0h", c, bus.PCD, bus.InstrD, bus.PCPlus4D, exp_pc, exp_pc ^ c_KEY, exp_pc + 32'd4);
            end
         end else begin
            n_checks++; if (bus.InstrD !== c_NOP || bus.PCD !== 32'h0 || bus.PCPlus4D !== 32'h0) begin
               n_fail++; $display("FAIL rand_idle c%0d got=%0h/%0h/%0h want=%0h/0/0", c, bus.InstrD, bus.PCD, bus.PCPlus4D, c_NOP);
            end
         end
         if (since >= 2) begin
            n_checks++; if (bus.ValidD !== 1'b1) begin n_fail++; $display("FAIL rand_live c%0d got=%0h want=1", c, bus.ValidD); end
         end
         if (rd) begin
            n_checks++; if (bus.ImemReq !== 1'b0) begin n_fail++; $display("FAIL rand_redir_req c%0d got=%0h want=0", c, bus.ImemReq); end
         end
         n_checks++; if (bus.ImemAddr[1:0] !== 2'b00) begin n_fail++; $display("FAIL rand_align c%0d got=%0h want=aligned", c, bus.ImemAddr); end
         if (rd) begin
            exp_pc = tg & ~32'h3;
            since  = -1;
         end else if (bus.ValidD === 1'b1 && !st) begin
            exp_pc = exp_pc + 32'd4;
         end
      end
   endtask

   initial begin
      reset_n       = 1'b0;
      bus.StallD    = 1'b0;
      bus.PCSrcE    = 1'b0;
      bus.PCTargetE = '0;
      test_reset();
      test_stream();
      test_stall();
      test_redirect();
      test_redirect_drop();
      test_misaligned();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end
endmodule
`default_nettype wire
